// File: rtl/alarm_controller.sv
// Alarm stage: holds a BCD HH:MM alarm time, detects the alarm minute and
// runs the ring/snooze/stop state machine that drives the buzzer.
module alarm_controller #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic [19:0] time_bcd,
    input  logic        arm,
    input  logic        set_mode,
    input  logic        inc_min,
    input  logic        dec_min,
    input  logic        inc_hour,
    input  logic        dec_hour,
    input  logic        stop,
    input  logic        snooze,
    output logic [12:0] alarm_time,
    output logic        ringing,
    output logic        buzzer,
    output logic [1:0]  state
);

    localparam int unsigned RW = $clog2(RING_SECS + 1);
    localparam int unsigned SW = $clog2(SNOOZE_SECS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZE  = 2'b10
    } state_t;

    state_t          st_q, st_d;
    logic [1:0]      ah_t, nh_t;
    logic [3:0]      ah_u, nh_u;
    logic [2:0]      am_t, nm_t;
    logic [3:0]      am_u, nm_u;
    logic [RW-1:0]   ring_cnt, ring_d;
    logic [SW-1:0]   snz_cnt, snz_d;
    logic            buz_d;
    logic            cond, cond_q, trigger;

    assign alarm_time = {ah_t, ah_u, am_t, am_u};
    assign state      = st_q;

    // Per-digit BCD edit; opposing pulses on one field cancel out.
    always_comb begin
        nh_t = ah_t;
        nh_u = ah_u;
        nm_t = am_t;
        nm_u = am_u;
        if (set_mode && inc_min && !dec_min) begin
            if (am_u == 4'd9) begin
                nm_u = 4'd0;
                nm_t = (am_t == 3'd5) ? 3'd0 : am_t + 3'd1;
            end else begin
                nm_u = am_u + 4'd1;
            end
        end else if (set_mode && dec_min && !inc_min) begin
            if (am_u == 4'd0) begin
                nm_u = 4'd9;
                nm_t = (am_t == 3'd0) ? 3'd5 : am_t - 3'd1;
            end else begin
                nm_u = am_u - 4'd1;
            end
        end
        if (set_mode && inc_hour && !dec_hour) begin
            if (ah_t == 2'd2 && ah_u == 4'd3) begin
                nh_t = 2'd0;
                nh_u = 4'd0;
            end else if (ah_u == 4'd9) begin
                nh_u = 4'd0;
                nh_t = ah_t + 2'd1;
            end else begin
                nh_u = ah_u + 4'd1;
            end
        end else if (set_mode && dec_hour && !inc_hour) begin
            if (ah_t == 2'd0 && ah_u == 4'd0) begin
                nh_t = 2'd2;
                nh_u = 4'd3;
            end else if (ah_u == 4'd0) begin
                nh_u = 4'd9;
                nh_t = ah_t - 2'd1;
            end else begin
                nh_u = ah_u - 4'd1;
            end
        end
    end

    assign cond    = arm && !set_mode && (time_bcd[19:7] == alarm_time) && (time_bcd[6:0] == 7'd0);
    assign trigger = cond && !cond_q;

    always_comb begin
        st_d   = st_q;
        ring_d = ring_cnt;
        snz_d  = snz_cnt;
        buz_d  = buzzer;
        case (st_q)
            IDLE: begin
                if (trigger) begin
                    st_d   = RINGING;
                    ring_d = RW'(RING_SECS);
                    buz_d  = 1'b1;
                end
            end
            RINGING: begin
                if (!arm || stop) begin
                    st_d = IDLE;
                end else if (snooze) begin
                    st_d  = SNOOZE;
                    snz_d = SW'(SNOOZE_SECS);
                end else if (tick_1hz) begin
                    ring_d = ring_cnt - RW'(1);
                    buz_d  = !buzzer;
                    if (ring_cnt == RW'(1)) st_d = IDLE;
                end
            end
            SNOOZE: begin
                if (!arm || stop) begin
                    st_d = IDLE;
                end else if (tick_1hz) begin
                    snz_d = snz_cnt - SW'(1);
                    if (snz_cnt == SW'(1)) begin
                        st_d   = RINGING;
                        ring_d = RW'(RING_SECS);
                        buz_d  = 1'b1;
                    end
                end
            end
            default: st_d = IDLE;
        endcase
        if (st_d != RINGING) buz_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q     <= IDLE;
            ah_t     <= '0;
            ah_u     <= '0;
            am_t     <= '0;
            am_u     <= '0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            cond_q   <= 1'b0;
            ringing  <= 1'b0;
            buzzer   <= 1'b0;
        end else begin
            st_q     <= st_d;
            ah_t     <= nh_t;
            ah_u     <= nh_u;
            am_t     <= nm_t;
            am_u     <= nm_u;
            ring_cnt <= ring_d;
            snz_cnt  <= snz_d;
            cond_q   <= cond;
            ringing  <= (st_d == RINGING);
            buzzer   <= buz_d;
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: expectations are queued as stimulus is
// driven and drained against the DUT one cycle later.
module tb_alarm_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_1hz;
    logic [19:0] time_bcd;
    logic        arm, set_mode;
    logic        inc_min, dec_min, inc_hour, dec_hour;
    logic        stop, snooze;
    logic [12:0] alarm_time;
    logic        ringing, buzzer;
    logic [1:0]  state;

    alarm_controller #(.RING_SECS(3), .SNOOZE_SECS(2)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .time_bcd(time_bcd),
        .arm(arm), .set_mode(set_mode),
        .inc_min(inc_min), .dec_min(dec_min), .inc_hour(inc_hour), .dec_hour(dec_hour),
        .stop(stop), .snooze(snooze),
        .alarm_time(alarm_time), .ringing(ringing), .buzzer(buzzer), .state(state)
    );

    always #5 clk = ~clk;

    typedef enum int {SEL_STATE, SEL_RING, SEL_BUZ, SEL_ATIME} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [19:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   mh = 0;
    int   mm = 0;

    function automatic logic [19:0] tw(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [12:0] bcd13(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    task automatic push(input string tag, input sel_t sel, input logic [19:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_out(input string tag, input logic [1:0] st, input logic r, input logic b);
        push({tag, ".state"},   SEL_STATE, {18'd0, st});
        push({tag, ".ringing"}, SEL_RING,  {19'd0, r});
        push({tag, ".buzzer"},  SEL_BUZ,   {19'd0, b});
    endtask

    task automatic push_atime(input string tag);
        push({tag, ".alarm_time"}, SEL_ATIME, {7'd0, bcd13(mh, mm)});
    endtask

    task automatic drain();
        exp_t        e;
        logic [19:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_STATE: obs = {18'd0, state};
                SEL_RING:  obs = {19'd0, ringing};
                SEL_BUZ:   obs = {19'd0, buzzer};
                default:   obs = {7'd0, alarm_time};
            endcase
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one clock, drop single-cycle pulses, then check what was queued.
    task automatic cyc();
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        inc_min  = 1'b0;
        dec_min  = 1'b0;
        inc_hour = 1'b0;
        dec_hour = 1'b0;
        stop     = 1'b0;
        snooze   = 1'b0;
        drain();
    endtask

    task automatic edit(input bit ih, input bit dh, input bit im, input bit dm, input string tag);
        inc_hour = ih;
        dec_hour = dh;
        inc_min  = im;
        dec_min  = dm;
        if (set_mode) begin
            if (ih && !dh) mh = (mh + 1) % 24;
            else if (dh && !ih) mh = (mh + 23) % 24;
            if (im && !dm) mm = (mm + 1) % 60;
            else if (dm && !im) mm = (mm + 59) % 60;
        end
        push_atime(tag);
        cyc();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; tick_1hz = 1'b0; time_bcd = '0; arm = 1'b0; set_mode = 1'b0;
        inc_min = 1'b0; dec_min = 1'b0; inc_hour = 1'b0; dec_hour = 1'b0;
        stop = 1'b0; snooze = 1'b0;
        #2;
        push_out("reset", 2'd0, 1'b0, 1'b0);
        push_atime("reset");
        drain();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Alarm-time editing
        set_mode = 1'b1;
        repeat (7)  edit(1, 0, 0, 0, "inc_hour");
        repeat (30) edit(0, 0, 1, 0, "inc_min");
        push("set_0730.alarm_time", SEL_ATIME, {7'd0, 13'b00_0111_011_0000});
        drain();
        edit(1, 1, 0, 0, "hour_inc_dec");
        edit(0, 0, 1, 1, "min_inc_dec");
        edit(1, 0, 1, 0, "both_inc");
        edit(0, 1, 0, 1, "both_dec");
        repeat (30) edit(0, 0, 0, 1, "dec_min");
        edit(0, 0, 0, 1, "min_wrap_dn");
        edit(0, 0, 1, 0, "min_wrap_up");
        repeat (7) edit(0, 1, 0, 0, "dec_hour");
        edit(0, 1, 0, 0, "hour_wrap_dn");
        edit(1, 0, 0, 0, "hour_wrap_up");
        repeat (7)  edit(1, 0, 1, 0, "restore");
        repeat (23) edit(0, 0, 1, 0, "restore_min");
        set_mode = 1'b0;
        edit(1, 0, 1, 0, "edit_locked");
        push("locked_0730.alarm_time", SEL_ATIME, {7'd0, 13'b00_0111_011_0000});
        drain();

        // Trigger and auto-stop after three ticks
        arm = 1'b1;
        time_bcd = tw(7, 29, 59); push_out("pre_alarm", 2'd0, 1'b0, 1'b0); cyc();
        time_bcd = tw(7, 30, 0);  push_out("trigger", 2'd1, 1'b1, 1'b1); cyc();
        repeat (3) begin push_out("hold_ring", 2'd1, 1'b1, 1'b1); cyc(); end
        tick_1hz = 1'b1; push_out("tick1", 2'd1, 1'b1, 1'b0); cyc();
        repeat (2) begin push_out("between_ticks", 2'd1, 1'b1, 1'b0); cyc(); end
        tick_1hz = 1'b1; push_out("tick2", 2'd1, 1'b1, 1'b1); cyc();
        tick_1hz = 1'b1; push_out("tick3_end", 2'd0, 1'b0, 1'b0); cyc();
        repeat (100) begin push_out("no_retrigger", 2'd0, 1'b0, 1'b0); cyc(); end

        // Entry tick not counted; snooze and re-ring
        time_bcd = tw(7, 29, 59); push_out("pre_alarm2", 2'd0, 1'b0, 1'b0); cyc();
        time_bcd = tw(7, 30, 0); tick_1hz = 1'b1; push_out("entry_tick", 2'd1, 1'b1, 1'b1); cyc();
        tick_1hz = 1'b1; push_out("ring_t1", 2'd1, 1'b1, 1'b0); cyc();
        tick_1hz = 1'b1; push_out("ring_t2", 2'd1, 1'b1, 1'b1); cyc();
        snooze = 1'b1;   push_out("snooze", 2'd2, 1'b0, 1'b0); cyc();
        snooze = 1'b1;   push_out("snooze_ignored", 2'd2, 1'b0, 1'b0); cyc();
        tick_1hz = 1'b1; push_out("snz_t1", 2'd2, 1'b0, 1'b0); cyc();
        tick_1hz = 1'b1; push_out("snz_rering", 2'd1, 1'b1, 1'b1); cyc();
        tick_1hz = 1'b1; push_out("ring_reloaded", 2'd1, 1'b1, 1'b0); cyc();
        stop = 1'b1; snooze = 1'b1; push_out("stop_and_snooze", 2'd0, 1'b0, 1'b0); cyc();
        stop = 1'b1;   push_out("stop_idle", 2'd0, 1'b0, 1'b0); cyc();
        snooze = 1'b1; push_out("snooze_idle", 2'd0, 1'b0, 1'b0); cyc();

        // Disarm while snoozing
        time_bcd = tw(7, 29, 59); push_out("pre_alarm3", 2'd0, 1'b0, 1'b0); cyc();
        time_bcd = tw(7, 30, 0);  push_out("trigger3", 2'd1, 1'b1, 1'b1); cyc();
        snooze = 1'b1; push_out("snooze3", 2'd2, 1'b0, 1'b0); cyc();
        arm = 1'b0;    push_out("disarm", 2'd0, 1'b0, 1'b0); cyc();
        time_bcd = tw(7, 31, 0); arm = 1'b1; push_out("rearm", 2'd0, 1'b0, 1'b0); cyc();

        // set_mode suppresses the trigger; releasing it inside second 00 fires
        time_bcd = tw(7, 29, 59); set_mode = 1'b1; push_out("pre_alarm4", 2'd0, 1'b0, 1'b0); cyc();
        time_bcd = tw(7, 30, 0);  push_out("set_mode_block", 2'd0, 1'b0, 1'b0); cyc();
        push_out("set_mode_block2", 2'd0, 1'b0, 1'b0); cyc();
        set_mode = 1'b0; push_out("release_set", 2'd1, 1'b1, 1'b1); cyc();

        // Asynchronous reset while snoozing
        snooze = 1'b1; push_out("snooze5", 2'd2, 1'b0, 1'b0); cyc();
        #2;
        reset = 1'b1;
        #1;
        mh = 0;
        mm = 0;
        push_out("async_reset", 2'd0, 1'b0, 1'b0);
        push_atime("async_reset");
        drain();
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_out("post_reset", 2'd0, 1'b0, 1'b0); push_atime("post_reset"); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm stage sitting directly downstream of the digital clock core. It consumes the 20-bit packed BCD time word, holds a user-set alarm time (HH:MM), and detects the alarm minute. It runs the ring/snooze/stop state machine and drives the buzzer and ringing indicator.

## Interface
- RING_SECS, 60, seconds (1 Hz ticks) the alarm rings before auto-stop; ≥1
- SNOOZE_SECS, 300, seconds spent in snooze before re-ringing; ≥1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_1hz  in  1  single-cycle pulse once per second, synchronous to clk
- time_bcd  in  20  current time {hour_tens[1:0], hour_units[3:0], min_tens[2:0], min_units[3:0], sec_tens[2:0], sec_units[3:0]}
- arm  in  1  level; alarm enabled
- set_mode  in  1  level; alarm-time edit mode
- inc_min, dec_min, inc_hour, dec_hour  in  1 each  single-cycle pulses, honoured only when set_mode=1
- stop  in  1  single-cycle pulse
- snooze  in  1  single-cycle pulse
- alarm_time  out  13  {hour_tens[1:0], hour_units[3:0], min_tens[2:0], min_units[3:0]}, registered
- ringing  out  1  registered; 1 in RINGING
- buzzer  out  1  registered tone-enable
- state  out  2  IDLE=00, RINGING=01, SNOOZE=10

## Operation
- Alarm-time edit, only when set_mode=1:
  - inc_min: 59→00; dec_min: 00→59. No carry into hours.
  - inc_hour: 23→00; dec_hour: 00→23.
  - Arithmetic is in BCD per digit pair; digits never leave legal ranges.
  - inc and dec of the same field in one cycle: field unchanged.
  - Minute and hour pulses in the same cycle: both applied.
- Trigger condition cond = arm & ~set_mode & (time_bcd[19:7] == alarm_time) & (time_bcd[6:0] == 0).
  - Registered copy cond_q. Trigger = cond & ~cond_q, the rising edge.
  - Only one trigger per alarm minute.
  - Releasing set_mode during second 00 of the alarm minute does trigger.
- FSM, priority within a cycle: ~arm > stop > snooze > tick-driven events.
  - IDLE: trigger → RINGING. Load ring_cnt=RING_SECS; buzzer=1.
  - RINGING:
    - stop → IDLE.
    - snooze → SNOOZE, load snz_cnt=SNOOZE_SECS.
    - On each tick: ring_cnt decrements and buzzer toggles (0.5 Hz pattern).
    - Tick with ring_cnt==1 → IDLE.
  - SNOOZE:
    - stop → IDLE.
    - On each tick, snz_cnt decrements.
    - Tick with snz_cnt==1 → RINGING, reload ring_cnt=RING_SECS, buzzer=1.
    - snooze ignored.
  - Any state with arm=0 → IDLE.
  - snooze and stop are ignored in IDLE. Trigger is ignored outside IDLE.
- buzzer=0 and ringing=0 in every state except RINGING.
- Counter widths: $clog2(param+1).

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, ringing=0, buzzer=0, alarm_time=00:00 (13'b0).
  - cond_q=0, ring_cnt=0, snz_cnt=0.
- Edit latency: alarm_time updates on the clk edge that samples the pulse.
- Trigger latency:
  - cond true in cycle N → ringing=1 and buzzer=1 visible after edge N+1.
  - cond_q is set at the same edge.
- Stop/snooze/disarm: outputs change on the edge that samples the input, one cycle.
- Ring duration is exactly RING_SECS ticks counted after entry. The entry cycle is not counted, even if a tick coincides with it.
- Reset asserted mid-ring or mid-snooze returns to IDLE. alarm_time is also cleared.

## Test plan
- Set alarm to 07:30: from 00:00 apply 7 inc_hour and 30 inc_min with set_mode=1 → alarm_time=13'b00_0111_011_0000. Then dec_min from 00 → 59, dec_hour from 00 → 23.
- Arm=1, drive time_bcd 07:29:59 → 07:30:00 → ringing=1 one cycle later. Hold 07:30:00 for 100 cycles → exactly one trigger; buzzer toggles on each tick.
- RING_SECS=3: no stop → ringing drops to 0 on the third tick; state=IDLE.
- Ringing, pulse snooze; SNOOZE_SECS=2 → state=SNOOZE, buzzer=0. After 2 ticks → RINGING, buzzer=1. Pulse stop → IDLE.
- stop and snooze in the same cycle while ringing → IDLE. arm dropped while in SNOOZE → IDLE next edge. set_mode=1 at the alarm minute → no trigger.
- Assert reset mid-SNOOZE → all outputs 0 and alarm_time=0 immediately, without waiting for a clk edge.
